// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage bundle: the instruction fields arriving from the MEM stage,
// the synchronous data-memory read word, and the register-file write port
// produced by the WB stage.
interface mem_wb_stage_if;
    // MEM-stage instruction fields
    logic        in_valid;
    logic        in_regwrite;
    logic [4:0]  in_wa;
    logic [31:0] in_alu;
    logic        in_memtoreg;
    logic [2:0]  in_ldtype;
    logic [1:0]  in_boff;

    // Data-memory read word, valid while the load occupies WB
    logic [31:0] dmem_rdata;

    // Register-file write port (also the WB forwarding source)
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    // Upstream side: drives the instruction and memory data, observes writeback
    modport master (
        output in_valid, in_regwrite, in_wa, in_alu, in_memtoreg, in_ldtype, in_boff,
        output dmem_rdata,
        input  rf_we, rf_wa, rf_wd
    );

    // WB stage side
    modport slave (
        input  in_valid, in_regwrite, in_wa, in_alu, in_memtoreg, in_ldtype, in_boff,
        input  dmem_rdata,
        output rf_we, rf_wa, rf_wd
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback logic.
// Holds one instruction in WB, aligns and extends load data from the
// big-endian data memory, produces the register-file write port, flags
// misaligned loads (sticky) and counts retired instructions.
module mem_wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    mem_wb_stage_if.slave    bus,
    output logic             wb_valid,
    output logic             err_misalign,
    output logic [CNT_W-1:0] instret
);

    // Load type encodings; anything outside this set behaves as a word load
    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_HU = 3'b010;
    localparam logic [2:0] LD_B  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;

    // WB register fields
    logic        wb_regwrite;
    logic [4:0]  wb_wa;
    logic [31:0] wb_alu;
    logic        wb_memtoreg;
    logic [2:0]  wb_ldtype;
    logic [1:0]  wb_boff;

    // Decoded load shape
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        is_signed;

    // Lane-selected and extended load data
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;
    logic        misaligned;

    // Pipeline register: flush inserts a bubble even when stalled, stall holds,
    // otherwise the MEM-stage instruction advances into WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_wa       <= 5'd0;
            wb_alu      <= 32'd0;
            wb_memtoreg <= 1'b0;
            wb_ldtype   <= 3'd0;
            wb_boff     <= 2'd0;
        end else if (flush) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
        end else if (!stall) begin
            wb_valid    <= bus.in_valid;
            wb_regwrite <= bus.in_regwrite;
            wb_wa       <= bus.in_wa;
            wb_alu      <= bus.in_alu;
            wb_memtoreg <= bus.in_memtoreg;
            wb_ldtype   <= bus.in_ldtype;
            wb_boff     <= bus.in_boff;
        end
    end

    // Decode the load type into access size and signedness
    always_comb begin
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        case (wb_ldtype)
            LD_H: begin
                is_half   = 1'b1;
                is_signed = 1'b1;
            end
            LD_HU: begin
                is_half   = 1'b1;
            end
            LD_B: begin
                is_byte   = 1'b1;
                is_signed = 1'b1;
            end
            LD_BU: begin
                is_byte   = 1'b1;
            end
            default: begin
                is_word   = 1'b1;
            end
        endcase
    end

    // Pick the addressed byte and halfword; byte 0 is the most significant
    always_comb begin
        byte_lane = bus.dmem_rdata[7:0];
        case (wb_boff)
            2'd0:    byte_lane = bus.dmem_rdata[31:24];
            2'd1:    byte_lane = bus.dmem_rdata[23:16];
            2'd2:    byte_lane = bus.dmem_rdata[15:8];
            default: byte_lane = bus.dmem_rdata[7:0];
        endcase
        half_lane = wb_boff[1] ? bus.dmem_rdata[15:0] : bus.dmem_rdata[31:16];
    end

    // Sign- or zero-extend the selected lane to a full register value
    always_comb begin
        load_data = bus.dmem_rdata;
        if (is_byte) begin
            load_data = {{24{is_signed & byte_lane[7]}}, byte_lane};
        end else if (is_half) begin
            load_data = {{16{is_signed & half_lane[15]}}, half_lane};
        end
    end

    // A load is misaligned when a word is not on a 4-byte boundary or a
    // halfword is on an odd byte; such loads retire without writing
    always_comb begin
        misaligned = wb_memtoreg &
                     ((is_word & (wb_boff != 2'd0)) | (is_half & wb_boff[0]));
    end

    // Register-file write port; the address is forced to zero for bubbles so
    // downstream forwarding never matches an empty slot
    always_comb begin
        bus.rf_wd = wb_memtoreg ? load_data : wb_alu;
        bus.rf_we = wb_valid & wb_regwrite & (wb_wa != 5'd0) & ~misaligned;
        bus.rf_wa = wb_valid ? wb_wa : 5'd0;
    end

    // Sticky misaligned-load flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_misalign <= 1'b0;
        end else if (wb_valid && misaligned) begin
            err_misalign <= 1'b1;
        end
    end

    // Retired-instruction counter: an instruction retires when it leaves WB,
    // which happens on any unstalled edge; wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (wb_valid && !stall) begin
            instret <= instret + CNT_W'(1);
        end
    end

endmodule
